lct_l1a_match: RTL

LCT_L1A_MATCH -- requirements
Module: lct_l1a_match

---
 rtl/dmb_lct_pkg.sv | 14 +
 rtl/lct_age_entry.sv | 36 +++
 rtl/lct_l1a_match.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/dmb_lct_pkg.sv
// Shared definitions for the LCT / L1A matching logic.
//   DEF_DEPTH  default number of pending-LCT entries
//   DEF_WIN_W  default width of the match window and of each age counter
//   pend_w()   width needed to hold a pending count of 0..depth
package dmb_lct_pkg;

    localparam int DEF_DEPTH = 4;
    localparam int DEF_WIN_W = 4;

    function automatic int pend_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lct_age_entry.sv
// One pending-LCT slot: a valid bit plus an age counter that counts clocks
// since the LCT was captured and sticks at all-ones instead of wrapping.
//   CLK       system clock, rising edge
//   RST_N     synchronous active-low reset (empties the slot)
//   clr       empty the slot
//   load      fill the slot with load_age (takes effect over the counting)
//   load_age  age written on load
//   valid     slot holds an LCT
//   age       clocks since the LCT was captured (saturating)
module lct_age_entry
    import dmb_lct_pkg::*;
#(
    parameter int WIN_W = DEF_WIN_W
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             clr,
    input  logic             load,
    input  logic [WIN_W-1:0] load_age,
    output logic             valid,
    output logic [WIN_W-1:0] age
);

    always_ff @(posedge CLK) begin
        if (!RST_N || clr) begin
            valid <= 1'b0;
            age   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            age   <= load_age;
        end else if (valid && (age != '1)) begin
            age <= age + WIN_W'(1);
        end
    end

endmodule

// File: rtl/lct_l1a_match.sv
// Matches level-1 accepts against delayed LCT pulses. Each LCT rising edge
// queues an entry; an L1A within WIN clocks of the oldest entry consumes it.
// Entries that reach WIN clocks unmatched are dropped from the head.
//   CLK          system clock, rising edge
//   RST_N        synchronous active-low reset
//   LCT          delayed LCT level; its rising edge is the event
//   L1A          level-1 accept pulse
//   WIN          match window in clocks, 0 disables matching
//   L1A_MATCH    pulse: L1A consumed a pending LCT
//   L1A_NOMATCH  pulse: L1A found nothing in the window
//   LCT_EXPIRED  pulse: oldest LCT aged out unmatched
//   LCT_OVF      pulse: LCT dropped because the queue was full
//   PENDING      number of queued entries
//   MATCH_CNT    saturating count of L1A_MATCH pulses
module lct_l1a_match
    import dmb_lct_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIN_W = DEF_WIN_W
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      LCT,
    input  logic                      L1A,
    input  logic [WIN_W-1:0]          WIN,
    output logic                      L1A_MATCH,
    output logic                      L1A_NOMATCH,
    output logic                      LCT_EXPIRED,
    output logic                      LCT_OVF,
    output logic [pend_w(DEPTH)-1:0]  PENDING,
    output logic [7:0]                MATCH_CNT
);

    localparam int PW = pend_w(DEPTH);

    // Queue is kept compacted: slot 0 is the oldest entry, valid slots are
    // 0..PENDING-1. The extra slot DEPTH is a permanently empty pad so the
    // shift logic can read slot i+1 without a range special case.
    logic             lct_q;
    logic             lct_evt;
    logic [DEPTH:0]   valid_ext;
    logic [WIN_W-1:0] age_ext [DEPTH+1];
    logic [DEPTH-1:0] ent_load;
    logic [DEPTH-1:0] ent_clr;
    logic [WIN_W-1:0] ent_load_age [DEPTH];
    logic [PW-1:0]    pend_q;
    logic [PW-1:0]    app_idx;
    logic [WIN_W:0]   head_k;
    logic [WIN_W:0]   win_x;
    logic             head_inwin, head_old;
    logic             match_head, match_new, nomatch;
    logic             expire, remove, full, evt_live, append, overflow;

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        lct_age_entry #(.WIN_W(WIN_W)) u_ent (
            .CLK      (CLK),
            .RST_N    (RST_N),
            .clr      (ent_clr[g]),
            .load     (ent_load[g]),
            .load_age (ent_load_age[g]),
            .valid    (valid_ext[g]),
            .age      (age_ext[g])
        );
    end

    assign valid_ext[DEPTH] = 1'b0;
    assign age_ext[DEPTH]   = '0;

    assign lct_evt = LCT && !lct_q;

    // The stored age lags by one: an entry loaded with 0 on its LCT edge
    // has been waiting k clocks at the edge where it reads k-1.
    assign head_k = {1'b0, age_ext[0]} + {{WIN_W{1'b0}}, 1'b1};
    assign win_x  = {1'b0, WIN};

    assign head_inwin = valid_ext[0] && (head_k < win_x);
    assign head_old   = valid_ext[0] && !(head_k < win_x);

    // An L1A on the same edge as an LCT edge matches that LCT directly
    // (k=0) when nothing older is queued; the LCT is then never queued.
    assign match_head = L1A && head_inwin;
    assign match_new  = L1A && lct_evt && !valid_ext[0] && (WIN != '0);
    assign nomatch    = L1A && !match_head && !match_new;

    // head_old and head_inwin are exclusive, so a match always wins.
    assign expire   = head_old;
    assign remove   = match_head || expire;
    assign full     = (pend_q == PW'(DEPTH));
    assign evt_live = lct_evt && !match_new;
    assign append   = evt_live && (!full || remove);
    assign overflow = evt_live && full && !remove;
    assign app_idx  = remove ? (pend_q - PW'(1)) : pend_q;

    always_comb begin
        ent_load = '0;
        ent_clr  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_load_age[i] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (remove) begin
                // Shift toward the head; the moved entry still ages this clock.
                if (valid_ext[i+1]) begin
                    ent_load[i]     = 1'b1;
                    ent_load_age[i] = (age_ext[i+1] == '1) ? age_ext[i+1]
                                                           : age_ext[i+1] + WIN_W'(1);
                end else begin
                    ent_clr[i] = 1'b1;
                end
            end
            if (append && (app_idx == PW'(i))) begin
                ent_load[i]     = 1'b1;
                ent_clr[i]      = 1'b0;
                ent_load_age[i] = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            // lct_q resets high so a level held through reset is not an edge.
            lct_q       <= 1'b1;
            pend_q      <= '0;
            L1A_MATCH   <= 1'b0;
            L1A_NOMATCH <= 1'b0;
            LCT_EXPIRED <= 1'b0;
            LCT_OVF     <= 1'b0;
            MATCH_CNT   <= 8'd0;
        end else begin
            lct_q       <= LCT;
            pend_q      <= pend_q + PW'(append) - PW'(remove);
            L1A_MATCH   <= match_head || match_new;
            L1A_NOMATCH <= nomatch;
            LCT_EXPIRED <= expire;
            LCT_OVF     <= overflow;
            if ((match_head || match_new) && (MATCH_CNT != 8'hFF)) begin
                MATCH_CNT <= MATCH_CNT + 8'd1;
            end
        end
    end

    assign PENDING = pend_q;

endmodule
